mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 48 ++++
 rtl/mc_wait_timer.sv | 34 +++
 rtl/mc_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and select encodings for the multicycle controller
// ADDIEX/ADDIWB exist only when MC_CTRL_ADDI_EN is defined.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_BEQEX  = 4'd8,
      S_JEX    = 4'd9,
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
`endif
      S_ABORT  = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // States that sit on the memory handshake and are subject to the timeout.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait counter with timeout compare
module mc_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (inc)
         count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // Fires on the MEM_TIMEOUT-th consecutive not-ready cycle; a ready in that cycle wins.
   assign expired = inc && (count_q == LAST);

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control FSM with memory wait timeout
// Define MC_CTRL_ADDI_EN to add the addi path (ADDIEX/ADDIWB).
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       branch,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       bus_err,
   output logic [3:0] state
);

   state_e state_q, state_d;
   logic   bus_err_q;
   logic   expired;

   mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_d != state_q),
      .inc     (is_wait_state(state_q) && !mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         bus_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_ABORT)
            bus_err_q <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALU_ADD;
      pc_src     = PC_ALU;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            // Gated by rst_n so a held reset never leaks a strobe through mem_ready.
            if (mem_ready) begin
               ir_write = rst_n;
               pc_write = rst_n;
               state_d  = S_DECODE;
            end else if (expired) begin
               state_d = S_ABORT;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMMSH;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_REXEC;
               OP_BEQ:       state_d = S_BEQEX;
               OP_J:         state_d = S_JEX;
`ifdef MC_CTRL_ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`else
               OP_ADDI:      state_d = S_FETCH;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready)    state_d = S_MEMWB;
            else if (expired) state_d = S_ABORT;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready)    state_d = S_FETCH;
            else if (expired) state_d = S_ABORT;
         end
         S_REXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQEX: begin
            branch    = 1'b1;
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PC_ALUOUT;
            state_d   = S_FETCH;
         end
         S_JEX: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = S_FETCH;
         end
`ifdef MC_CTRL_ADDI_EN
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   assign bus_err = bus_err_q;
   assign state   = state_q;

endmodule
